// File: rtl/i2c_burst_ctrl.sv
// Burst sequencer in front of the i2c master core: splits one command into single-word core transfers.
// Optional watchdog on the core handshake enabled by defining I2C_BURST_TIMEOUT_EN.
module i2c_burst_ctrl #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 8,
  parameter int LEN_W          = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int ADDR_STEP      = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [6:0]        cmd_chip_addr,
  input  logic [ADDR_W-1:0] cmd_reg_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic [6:0]        core_chip_addr,
  output logic [ADDR_W-1:0] core_reg_addr,
  output logic              core_write_en,
  output logic              core_read_en,
  output logic [DATA_W-1:0] core_data_in,
  input  logic [DATA_W-1:0] core_data_out,
  input  logic              core_busy,
  input  logic [3:0]        core_status,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [3:0]        err_code,
  output logic [LEN_W:0]    words_done
);

  localparam int PW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("i2c_burst_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, WAIT_START, WAIT_END, NEXT, RDOUT, FINISH
  } state_t;

  typedef struct packed {
    logic             rw;
    logic [6:0]       chip;
    logic [LEN_W-1:0] len;
  } cmd_t;

  state_t            state, state_nxt;
  cmd_t              cmd_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [LEN_W:0]    wd_inc, len_p1;
  logic              timeout;

  // write-data FIFO; pointers carry one extra wrap bit to tell full from empty
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr;
  logic              empty, full, push, pop;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop         = (state == ISSUE) && !cmd_q.rw;
  assign wdata_ready = !full || pop;
  assign push        = wdata_valid && wdata_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

`ifdef I2C_BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          in_wait;

  assign in_wait = (state == WAIT_START) || (state == WAIT_END);
  assign timeout = in_wait && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            to_cnt <= '0;
    else if (!in_wait || state_nxt != state) to_cnt <= '0;
    else                                  to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  assign wd_inc      = words_done + 1'b1;
  assign len_p1      = {1'b0, cmd_q.len} + 1'b1;
  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);
  assign rdata_valid = (state == RDOUT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (cmd_valid) state_nxt = LOAD;
      LOAD:       if (cmd_q.rw || !empty) state_nxt = ISSUE;
      ISSUE:      state_nxt = WAIT_START;
      WAIT_START: begin
        if (timeout)        state_nxt = FINISH;
        else if (core_busy) state_nxt = WAIT_END;
      end
      WAIT_END: begin
        if (timeout)                  state_nxt = FINISH;
        else if (!core_busy) begin
          if (core_status != 4'h0)    state_nxt = FINISH;
          else if (cmd_q.rw)          state_nxt = RDOUT;
          else                        state_nxt = NEXT;
        end
      end
      RDOUT:      if (rdata_ready) state_nxt = NEXT;
      NEXT:       state_nxt = (wd_inc == len_p1) ? FINISH : LOAD;
      FINISH:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // core strobes are registered so they line up with the registered address/data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cmd_q          <= '0;
      reg_addr_q     <= '0;
      words_done     <= '0;
      error          <= 1'b0;
      err_code       <= 4'h0;
      rdata          <= '0;
      core_chip_addr <= '0;
      core_reg_addr  <= '0;
      core_data_in   <= '0;
      core_write_en  <= 1'b0;
      core_read_en   <= 1'b0;
    end else begin
      state         <= state_nxt;
      core_write_en <= (state == ISSUE) && !cmd_q.rw;
      core_read_en  <= (state == ISSUE) && cmd_q.rw;
      if (timeout) begin
        error    <= 1'b1;
        err_code <= 4'hF;
      end else begin
        case (state)
          IDLE: if (cmd_valid) begin
            cmd_q      <= '{rw: cmd_rw, chip: cmd_chip_addr, len: cmd_len};
            reg_addr_q <= cmd_reg_addr;
            words_done <= '0;
            error      <= 1'b0;
            err_code   <= 4'h0;
          end
          ISSUE: begin
            core_chip_addr <= cmd_q.chip;
            core_reg_addr  <= reg_addr_q;
            if (!cmd_q.rw) core_data_in <= mem[rd_ptr[PW-1:0]];
          end
          WAIT_END: if (!core_busy) begin
            if (core_status != 4'h0) begin
              error    <= 1'b1;
              err_code <= core_status;
            end else if (cmd_q.rw) begin
              rdata <= core_data_out;
            end
          end
          NEXT: begin
            words_done <= wd_inc;
            reg_addr_q <= reg_addr_q + ADDR_W'(ADDR_STEP);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_burst_ctrl.sv
// Directed bench for i2c_burst_ctrl with a small behavioural i2c core model.
module tb_i2c_burst_ctrl;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [6:0]        cmd_chip_addr = '0;
  logic [ADDR_W-1:0] cmd_reg_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              wdata_valid = 1'b0, wdata_ready;
  logic [DATA_W-1:0] wdata = '0;
  logic              rdata_valid, rdata_ready = 1'b0;
  logic [DATA_W-1:0] rdata;
  logic [6:0]        core_chip_addr;
  logic [ADDR_W-1:0] core_reg_addr;
  logic              core_write_en, core_read_en;
  logic [DATA_W-1:0] core_data_in, core_data_out;
  logic              core_busy;
  logic [3:0]        core_status;
  logic              busy, done, error;
  logic [3:0]        err_code;
  logic [LEN_W:0]    words_done;

  i2c_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(8),
                   .ADDR_STEP(1), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_chip_addr(cmd_chip_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .core_chip_addr(core_chip_addr), .core_reg_addr(core_reg_addr),
    .core_write_en(core_write_en), .core_read_en(core_read_en),
    .core_data_in(core_data_in), .core_data_out(core_data_out),
    .core_busy(core_busy), .core_status(core_status),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .words_done(words_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // transfer log and core behaviour knobs
  logic [ADDR_W-1:0] log_reg [64];
  logic [DATA_W-1:0] log_data[64];
  logic [6:0]        log_chip[64];
  logic              log_rw  [64];
  int                n_xfer = 0, done_cnt = 0, fail_at = -1;
  logic [3:0]        fail_status = 4'h0;
  bit                hang = 1'b0;

  // core model: busy rises after a start pulse, drops 3 cycles later with status and read data
  initial begin
    int rem;
    logic [ADDR_W-1:0] cur_reg;
    rem = 0; cur_reg = '0;
    core_busy = 1'b0; core_status = 4'h0; core_data_out = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        core_busy = 1'b0; core_status = 4'h0; rem = 0;
      end else begin
        if (done) done_cnt++;
        if (core_write_en || core_read_en) begin
          if (n_xfer < 64) begin
            log_reg[n_xfer] = core_reg_addr; log_data[n_xfer] = core_data_in;
            log_chip[n_xfer] = core_chip_addr; log_rw[n_xfer] = core_read_en;
          end
          n_xfer++;
          cur_reg = core_reg_addr;
          core_status = 4'h0; core_busy = 1'b1; rem = 3;
        end else if (core_busy && !hang) begin
          if (rem > 1) rem--;
          else begin
            core_busy = 1'b0;
            core_status = (n_xfer - 1 == fail_at) ? fail_status : 4'h0;
            core_data_out = {8'h5A, cur_reg};
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic rw, input logic [6:0] chip, input logic [ADDR_W-1:0] ra,
                          input logic [LEN_W-1:0] len);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_chip_addr = chip; cmd_reg_addr = ra; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    wdata_valid = 1'b1; wdata = w;
    tick();
    wdata_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (!busy) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (wdata_ready !== 1'b1) begin errors++; $display("FAIL reset_wdata_ready got %b want 1", wdata_ready); end
    checks++; if ({busy, done, error, rdata_valid, core_write_en, core_read_en} !== 6'b0)
      begin errors++; $display("FAIL reset_flags got %b want 000000", {busy, done, error, rdata_valid, core_write_en, core_read_en}); end
    checks++; if ({err_code, words_done, rdata, core_reg_addr} !== '0)
      begin errors++; $display("FAIL reset_values err_code %h words_done %0d rdata %h reg %h want 0", err_code, words_done, rdata, core_reg_addr); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_burst();
    logic [DATA_W-1:0] w[4] = '{16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4};
    int n0, d0;
    bit ok;
    n0 = n_xfer; d0 = done_cnt;
    for (int i = 0; i < 4; i++) push_word(w[i]);
    send_cmd(1'b0, 7'h0F, 8'h10, 4'd3);
    checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_busy busy %b cmd_ready %b want 1 0", busy, cmd_ready); end
    tick();
    checks++; if (core_write_en !== 1'b0) begin errors++; $display("FAIL wr_latency_early got %b want 0", core_write_en); end
    tick();
    checks++; if (core_write_en !== 1'b1 || core_read_en !== 1'b0)
      begin errors++; $display("FAIL wr_latency got we %b re %b want 1 0", core_write_en, core_read_en); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_timeout busy %b want 0", busy); end
    checks++; if (n_xfer - n0 !== 4) begin errors++; $display("FAIL wr_count got %0d want 4", n_xfer - n0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_reg[n0+i] !== 8'h10 + 8'(i) || log_data[n0+i] !== w[i] || log_chip[n0+i] !== 7'h0F || log_rw[n0+i] !== 1'b0)
        begin errors++; $display("FAIL wr_word%0d got reg %h data %h chip %h rw %b want %h %h 0f 0", i,
                                 log_reg[n0+i], log_data[n0+i], log_chip[n0+i], log_rw[n0+i], 8'h10 + 8'(i), w[i]); end
    end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL wr_done got %0d want 1", done_cnt - d0); end
    checks++; if (words_done !== 5'd4 || error !== 1'b0)
      begin errors++; $display("FAIL wr_status words_done %0d error %b want 4 0", words_done, error); end
  endtask

  task automatic test_read_burst();
    logic [DATA_W-1:0] expd[3] = '{16'h5AFE, 16'h5AFF, 16'h5A00};
    logic [ADDR_W-1:0] expr[3] = '{8'hFE, 8'hFF, 8'h00};
    int n0, k;
    bit ok;
    n0 = n_xfer; k = 0;
    rdata_ready = 1'b0;
    send_cmd(1'b1, 7'h0F, 8'hFE, 4'd2);
    for (int c = 0; c < 300 && k < 3; c++) begin
      tick();
      if (rdata_valid) begin
        checks++; if (rdata !== expd[k]) begin errors++; $display("FAIL rd_data%0d got %h want %h", k, rdata, expd[k]); end
        if (k == 1) begin
          repeat (5) begin
            tick();
            checks++;
            if (rdata_valid !== 1'b1 || rdata !== expd[1])
              begin errors++; $display("FAIL rd_stall valid %b data %h want 1 %h", rdata_valid, rdata, expd[1]); end
          end
        end
        rdata_ready = 1'b1;
        tick();
        rdata_ready = 1'b0;
        k++;
      end
    end
    checks++; if (k !== 3) begin errors++; $display("FAIL rd_delivered got %0d want 3", k); end
    wait_idle(ok);
    checks++; if (!ok || words_done !== 5'd3 || error !== 1'b0)
      begin errors++; $display("FAIL rd_end idle %b words_done %0d error %b want 1 3 0", ok, words_done, error); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_reg[n0+i] !== expr[i] || log_rw[n0+i] !== 1'b1)
        begin errors++; $display("FAIL rd_reg%0d got %h rw %b want %h 1", i, log_reg[n0+i], log_rw[n0+i], expr[i]); end
    end
  endtask

  task automatic test_load_stall();
    int n0;
    bit ok;
    n0 = n_xfer;
    send_cmd(1'b0, 7'h0F, 8'h20, 4'd1);
    repeat (20) tick();
    checks++; if (n_xfer !== n0 || busy !== 1'b1)
      begin errors++; $display("FAIL stall_issued xfers %0d busy %b want 0 1", n_xfer - n0, busy); end
    push_word(16'h1111);
    for (int i = 0; i < 20 && n_xfer == n0; i++) tick();
    checks++; if (n_xfer - n0 !== 1 || log_data[n0] !== 16'h1111 || log_reg[n0] !== 8'h20)
      begin errors++; $display("FAIL stall_first xfers %0d data %h reg %h want 1 1111 20", n_xfer - n0, log_data[n0], log_reg[n0]); end
    push_word(16'h2222);
    wait_idle(ok);
    checks++; if (!ok || words_done !== 5'd2 || log_data[n0+1] !== 16'h2222 || log_reg[n0+1] !== 8'h21)
      begin errors++; $display("FAIL stall_second idle %b words_done %0d data %h reg %h want 1 2 2222 21", ok, words_done, log_data[n0+1], log_reg[n0+1]); end
  endtask

  task automatic test_error();
    int n0, d0;
    bit ok;
    n0 = n_xfer; d0 = done_cnt;
    for (int i = 0; i < 4; i++) push_word(16'h1001 + 16'(i));
    fail_at = n0 + 1; fail_status = 4'h2;
    send_cmd(1'b0, 7'h0F, 8'h40, 4'd3);
    wait_idle(ok);
    fail_at = -1;
    checks++; if (!ok || error !== 1'b1 || err_code !== 4'h2)
      begin errors++; $display("FAIL err_flag idle %b error %b code %h want 1 1 2", ok, error, err_code); end
    checks++; if (words_done !== 5'd1 || n_xfer - n0 !== 2 || done_cnt - d0 !== 1)
      begin errors++; $display("FAIL err_progress words_done %0d xfers %0d done %0d want 1 2 1", words_done, n_xfer - n0, done_cnt - d0); end
    send_cmd(1'b0, 7'h0F, 8'h50, 4'd1);
    checks++; if (error !== 1'b0 || err_code !== 4'h0)
      begin errors++; $display("FAIL err_clear error %b code %h want 0 0", error, err_code); end
    wait_idle(ok);
    checks++; if (!ok || error !== 1'b0 || words_done !== 5'd2 || log_data[n0+2] !== 16'h1003 || log_data[n0+3] !== 16'h1004)
      begin errors++; $display("FAIL err_fifo_kept idle %b error %b words_done %0d data %h %h want 1 0 2 1003 1004",
                               ok, error, words_done, log_data[n0+2], log_data[n0+3]); end
  endtask

  task automatic test_reset_mid();
    int n0, d0;
    bit ok;
    for (int i = 0; i < 3; i++) push_word(16'h3000 + 16'(i));
    send_cmd(1'b0, 7'h0F, 8'h60, 4'd3);
    for (int i = 0; i < 20 && !core_busy; i++) tick();
    tick();
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    checks++; if ({busy, done, error, core_write_en, core_read_en, rdata_valid} !== 6'b0 || cmd_ready !== 1'b1 || wdata_ready !== 1'b1)
      begin errors++; $display("FAIL rst_mid_outputs busy %b done %b error %b we %b cmd_ready %b", busy, done, error, core_write_en, cmd_ready); end
    checks++; if ({err_code, words_done, core_reg_addr, core_data_in} !== '0)
      begin errors++; $display("FAIL rst_mid_values words_done %0d reg %h data %h want 0", words_done, core_reg_addr, core_data_in); end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1 || done_cnt !== d0)
      begin errors++; $display("FAIL rst_mid_release cmd_ready %b done %0d want 1 0", cmd_ready, done_cnt - d0); end
    n0 = n_xfer;
    send_cmd(1'b0, 7'h0F, 8'h70, 4'd0);
    repeat (10) tick();
    checks++; if (n_xfer !== n0 || busy !== 1'b1)
      begin errors++; $display("FAIL rst_mid_fifo_empty xfers %0d busy %b want 0 1", n_xfer - n0, busy); end
    push_word(16'h7777);
    wait_idle(ok);
    checks++; if (!ok || log_data[n0] !== 16'h7777 || log_reg[n0] !== 8'h70)
      begin errors++; $display("FAIL rst_mid_after idle %b data %h reg %h want 1 7777 70", ok, log_data[n0], log_reg[n0]); end
  endtask

  task automatic test_hang();
    bit ok;
    hang = 1'b1;
    send_cmd(1'b1, 7'h0F, 8'h80, 4'd0);
    repeat (150) tick();
`ifdef I2C_BURST_TIMEOUT_EN
    wait_idle(ok);
    checks++; if (error !== 1'b1 || err_code !== 4'hF)
      begin errors++; $display("FAIL hang_timeout error %b code %h want 1 f", error, err_code); end
`else
    ok = 1'b1;
    checks++; if (busy !== 1'b1 || error !== 1'b0)
      begin errors++; $display("FAIL hang_wait busy %b error %b want 1 0", busy, error); end
`endif
    hang = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (!ok || busy !== 1'b0 || cmd_ready !== 1'b1)
      begin errors++; $display("FAIL hang_recover idle %b busy %b cmd_ready %b want 1 0 1", ok, busy, cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_load_stall();
    test_error();
    test_reset_mid();
    test_hang();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
